// File: rtl/axi_data_mem_slave.sv
// AXI4 slave data memory: independent read and write burst FSMs over a 1W/1R word array.
// Define AXI_DATA_MEM_DECERR_EN to answer out-of-range beats with DECERR instead of aliasing.
module axi_data_mem_slave #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH = 1,
  parameter int unsigned MEM_DEPTH = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);
  localparam int unsigned BPB = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(BPB);
  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned TOP_SHIFT = OFF_W + IDX_W;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
`ifdef AXI_DATA_MEM_DECERR_EN
  localparam bit DECERR_EN = 1'b1;
`else
  localparam bit DECERR_EN = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // ---------------- write channel ----------------
  w_state_t w_state, w_state_d;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_addr_d, wr_off;
  logic [7:0] wr_len, wr_len_d, wr_cnt, wr_cnt_d;
  logic wr_incr, wr_incr_d, wr_legal, wr_legal_d, wr_slv, wr_slv_d, wr_dec, wr_dec_d;
  logic awready_d, wready_d, bvalid_d;
  logic [1:0] bresp_d;
  logic [ID_WIDTH-1:0] bid_d;
  logic [IDX_W-1:0] wr_idx;
  logic wr_in_range, wr_last, aw_legal, mem_we, slv_now, dec_now;

  assign wr_off      = wr_addr - BASE_ADDR;
  assign wr_idx      = wr_off[OFF_W +: IDX_W];
  assign wr_in_range = (wr_addr >= BASE_ADDR) && ((wr_off >> TOP_SHIFT) == '0);
  assign wr_last     = (wr_cnt == wr_len);
  assign aw_legal    = !s_axi_awburst[1] && (s_axi_awsize == 3'(OFF_W));

  always_comb begin
    w_state_d = w_state;
    wr_addr_d = wr_addr;
    wr_len_d = wr_len;
    wr_cnt_d = wr_cnt;
    wr_incr_d = wr_incr;
    wr_legal_d = wr_legal;
    wr_slv_d = wr_slv;
    wr_dec_d = wr_dec;
    awready_d = s_axi_awready;
    wready_d = s_axi_wready;
    bvalid_d = s_axi_bvalid;
    bresp_d = s_axi_bresp;
    bid_d = s_axi_bid;
    mem_we = 1'b0;
    slv_now = wr_slv;
    dec_now = wr_dec;
    case (w_state)
      W_IDLE: begin
        awready_d = 1'b1;
        if (s_axi_awvalid && s_axi_awready) begin
          wr_addr_d = s_axi_awaddr;
          wr_len_d = s_axi_awlen;
          wr_cnt_d = '0;
          wr_incr_d = (s_axi_awburst == 2'b01);
          wr_legal_d = aw_legal;
          wr_slv_d = !aw_legal;
          wr_dec_d = 1'b0;
          bid_d = s_axi_awid;
          awready_d = 1'b0;
          wready_d = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid && s_axi_wready) begin
          mem_we = wr_legal && (!DECERR_EN || wr_in_range);
          slv_now = wr_slv || (s_axi_wlast != wr_last);
          dec_now = wr_dec || (DECERR_EN && !wr_in_range);
          wr_slv_d = slv_now;
          wr_dec_d = dec_now;
          wr_cnt_d = wr_cnt + 8'd1;
          wr_addr_d = wr_incr ? wr_addr + ADDR_WIDTH'(BPB) : wr_addr;
          if (wr_last) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d = slv_now ? RESP_SLVERR : (dec_now ? RESP_DECERR : RESP_OKAY);
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (s_axi_bvalid && s_axi_bready) begin
          bvalid_d = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state <= W_IDLE;
      wr_addr <= '0;
      wr_len <= '0;
      wr_cnt <= '0;
      wr_incr <= 1'b0;
      wr_legal <= 1'b0;
      wr_slv <= 1'b0;
      wr_dec <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_wready <= 1'b0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp <= '0;
      s_axi_bid <= '0;
    end else begin
      w_state <= w_state_d;
      wr_addr <= wr_addr_d;
      wr_len <= wr_len_d;
      wr_cnt <= wr_cnt_d;
      wr_incr <= wr_incr_d;
      wr_legal <= wr_legal_d;
      wr_slv <= wr_slv_d;
      wr_dec <= wr_dec_d;
      s_axi_awready <= awready_d;
      s_axi_wready <= wready_d;
      s_axi_bvalid <= bvalid_d;
      s_axi_bresp <= bresp_d;
      s_axi_bid <= bid_d;
    end
  end

  // Array is never reset; byte lanes follow wstrb.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < BPB; b++) begin
        if (s_axi_wstrb[b]) mem[wr_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_t r_state, r_state_d;
  logic [ADDR_WIDTH-1:0] rd_addr, rd_addr_d, rd_addr_next, lk_addr, lk_off;
  logic [7:0] rd_len, rd_len_d, rd_cnt, rd_cnt_d;
  logic rd_incr, rd_incr_d, rd_legal, rd_legal_d, ar_legal, lk_legal, lk_in_range;
  logic [IDX_W-1:0] lk_idx;
  logic [DATA_WIDTH-1:0] lk_data, rdata_d;
  logic [1:0] lk_resp, rresp_d;
  logic arready_d, rvalid_d, rlast_d;
  logic [ID_WIDTH-1:0] rid_d;

  // Lookup targets beat 0 while idle, otherwise the beat after the current one.
  assign ar_legal     = !s_axi_arburst[1] && (s_axi_arsize == 3'(OFF_W));
  assign rd_addr_next = rd_incr ? rd_addr + ADDR_WIDTH'(BPB) : rd_addr;
  assign lk_addr      = (r_state == R_IDLE) ? s_axi_araddr : rd_addr_next;
  assign lk_legal     = (r_state == R_IDLE) ? ar_legal : rd_legal;
  assign lk_off       = lk_addr - BASE_ADDR;
  assign lk_idx       = lk_off[OFF_W +: IDX_W];
  assign lk_in_range  = (lk_addr >= BASE_ADDR) && ((lk_off >> TOP_SHIFT) == '0);
  assign lk_data      = (!lk_legal || (DECERR_EN && !lk_in_range)) ? '0 : mem[lk_idx];
  assign lk_resp      = !lk_legal ? RESP_SLVERR :
                        ((DECERR_EN && !lk_in_range) ? RESP_DECERR : RESP_OKAY);

  always_comb begin
    r_state_d = r_state;
    rd_addr_d = rd_addr;
    rd_len_d = rd_len;
    rd_cnt_d = rd_cnt;
    rd_incr_d = rd_incr;
    rd_legal_d = rd_legal;
    arready_d = s_axi_arready;
    rvalid_d = s_axi_rvalid;
    rlast_d = s_axi_rlast;
    rdata_d = s_axi_rdata;
    rresp_d = s_axi_rresp;
    rid_d = s_axi_rid;
    case (r_state)
      R_IDLE: begin
        arready_d = 1'b1;
        if (s_axi_arvalid && s_axi_arready) begin
          rd_addr_d = s_axi_araddr;
          rd_len_d = s_axi_arlen;
          rd_cnt_d = '0;
          rd_incr_d = (s_axi_arburst == 2'b01);
          rd_legal_d = ar_legal;
          arready_d = 1'b0;
          rvalid_d = 1'b1;
          rlast_d = (s_axi_arlen == 8'd0);
          rdata_d = lk_data;
          rresp_d = lk_resp;
          rid_d = s_axi_arid;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi_rvalid && s_axi_rready) begin
          if (rd_cnt == rd_len) begin
            rvalid_d = 1'b0;
            rlast_d = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            rd_cnt_d = rd_cnt + 8'd1;
            rd_addr_d = rd_addr_next;
            rdata_d = lk_data;
            rresp_d = lk_resp;
            rlast_d = ((rd_cnt + 8'd1) == rd_len);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= R_IDLE;
      rd_addr <= '0;
      rd_len <= '0;
      rd_cnt <= '0;
      rd_incr <= 1'b0;
      rd_legal <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid <= 1'b0;
      s_axi_rlast <= 1'b0;
      s_axi_rdata <= '0;
      s_axi_rresp <= '0;
      s_axi_rid <= '0;
    end else begin
      r_state <= r_state_d;
      rd_addr <= rd_addr_d;
      rd_len <= rd_len_d;
      rd_cnt <= rd_cnt_d;
      rd_incr <= rd_incr_d;
      rd_legal <= rd_legal_d;
      s_axi_arready <= arready_d;
      s_axi_rvalid <= rvalid_d;
      s_axi_rlast <= rlast_d;
      s_axi_rdata <= rdata_d;
      s_axi_rresp <= rresp_d;
      s_axi_rid <= rid_d;
    end
  end
endmodule

// File: tb/tb_axi_data_mem_slave.sv
// Randomized bench for axi_data_mem_slave against a byte-level memory model.
// Honours AXI_DATA_MEM_DECERR_EN to select the expected out-of-range behaviour.
module tb_axi_data_mem_slave;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 1;
  localparam int unsigned DEPTH = 1024;
`ifdef AXI_DATA_MEM_DECERR_EN
  localparam bit DECERR_EN = 1'b1;
`else
  localparam bit DECERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [IW-1:0] s_axi_awid = '0, s_axi_arid = '0, s_axi_bid, s_axi_rid;
  logic [AW-1:0] s_axi_awaddr = '0, s_axi_araddr = '0;
  logic [7:0] s_axi_awlen = '0, s_axi_arlen = '0;
  logic [2:0] s_axi_awsize = 3'd2, s_axi_arsize = 3'd2;
  logic [1:0] s_axi_awburst = 2'd1, s_axi_arburst = 2'd1, s_axi_bresp, s_axi_rresp;
  logic s_axi_awvalid = 1'b0, s_axi_awready, s_axi_wvalid = 1'b0, s_axi_wready;
  logic [DW-1:0] s_axi_wdata = '0, s_axi_rdata;
  logic [DW/8-1:0] s_axi_wstrb = '0;
  logic s_axi_wlast = 1'b0, s_axi_bvalid, s_axi_bready = 1'b0;
  logic s_axi_arvalid = 1'b0, s_axi_arready, s_axi_rlast, s_axi_rvalid, s_axi_rready = 1'b0;

  axi_data_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_DEPTH(DEPTH),
                       .BASE_ADDR('0)) dut (
    .clk(clk), .reset(reset),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] wbuf [256];
  logic [3:0]  sbuf [256];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] addr, input int b,
                                            input logic [1:0] burst);
    return (burst == 2'd1) ? addr + 32'(4 * b) : addr;
  endfunction

  function automatic bit in_mem(input logic [31:0] a);
    return !DECERR_EN || (a < 32'(4 * DEPTH));
  endfunction

  function automatic logic [9:0] widx(input logic [31:0] a);
    return 10'((a >> 2) % 32'(DEPTH));
  endfunction

  // Full write burst; model updated beat by beat, bad_last flips wlast on that beat.
  task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [2:0] size, input int bad_last, input bit gaps);
    logic [IW-1:0] id;
    logic [31:0] a;
    logic [1:0] exp_resp;
    bit legal, slv, dec, lastf;
    int n;
    id = IW'($urandom);
    legal = (burst <= 2'd1) && (size == 3'd2);
    slv = !legal;
    dec = 1'b0;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len);
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check_eq("aw_timeout", 64'(n), 64'(0));
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    check_eq("wready_lat", 64'({s_axi_wready, s_axi_awready}), 64'(2'b10));
    for (int b = 0; b <= len; b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_axi_wvalid = 1'b0;
        @(negedge clk);
      end
      lastf = (b == len) ^ (b == bad_last);
      s_axi_wvalid = 1'b1; s_axi_wdata = wbuf[b]; s_axi_wstrb = sbuf[b]; s_axi_wlast = lastf;
      n = 0;
      while (!s_axi_wready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) check_eq("w_timeout", 64'(n), 64'(0));
      @(negedge clk);
      a = beat_addr(addr, b, burst);
      if (lastf != (b == len)) slv = 1'b1;
      if (!in_mem(a)) dec = 1'b1;
      if (legal && in_mem(a))
        for (int k = 0; k < 4; k++)
          if (sbuf[b][k]) model[widx(a)][k*8 +: 8] = wbuf[b][k*8 +: 8];
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast = 1'b0;
    check_eq("bvalid_lat", 64'(s_axi_bvalid), 64'(1));
    repeat ($urandom_range(0, 2)) @(negedge clk);
    exp_resp = slv ? 2'b10 : (dec ? 2'b11 : 2'b00);
    check_eq("bresp", 64'({s_axi_bvalid, s_axi_bresp}), 64'({1'b1, exp_resp}));
    check_eq("bid", 64'(s_axi_bid), 64'(id));
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
    check_eq("b_done", 64'({s_axi_bvalid, s_axi_awready}), 64'(2'b01));
  endtask

  // Full read burst; stall 0 none, 1 rready toggles every cycle, 2 random.
  task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                         input logic [2:0] size, input int stall);
    logic [IW-1:0] id;
    logic [31:0] a, exp_d;
    logic [1:0] exp_r;
    bit legal;
    int n, ns;
    id = IW'($urandom);
    legal = (burst <= 2'd1) && (size == 3'd2);
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len);
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check_eq("ar_timeout", 64'(n), 64'(0));
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    check_eq("rvalid_lat", 64'({s_axi_rvalid, s_axi_arready}), 64'(2'b10));
    for (int b = 0; b <= len; b++) begin
      a = beat_addr(addr, b, burst);
      if (!legal) begin exp_d = '0; exp_r = 2'b10; end
      else if (!in_mem(a)) begin exp_d = '0; exp_r = 2'b11; end
      else begin exp_d = model[widx(a)]; exp_r = 2'b00; end
      ns = (stall == 1) ? 1 : ((stall == 2) ? $urandom_range(0, 2) : 0);
      s_axi_rready = 1'b0;
      for (int s = 0; s < ns; s++) begin
        @(negedge clk);
        check_eq("r_hold", 64'({s_axi_rvalid, s_axi_rlast, s_axi_rdata}),
                 64'({1'b1, b == len, exp_d}));
      end
      s_axi_rready = 1'b1;
      check_eq("rdata", 64'(s_axi_rdata), 64'(exp_d));
      check_eq("rresp_rlast", 64'({s_axi_rvalid, s_axi_rresp, s_axi_rlast}),
               64'({1'b1, exp_r, b == len}));
      check_eq("rid", 64'(s_axi_rid), 64'(id));
      @(negedge clk);
    end
    s_axi_rready = 1'b0;
    check_eq("r_done", 64'({s_axi_rvalid, s_axi_arready}), 64'(2'b01));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] old_v, new_v, addr;
    int len, r, bad;
    logic [1:0] burst;
    logic [2:0] size;

    // Reset: every output low while asserted, ready rises one edge after release.
    repeat (3) @(negedge clk);
    check_eq("reset_outs", 64'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready,
                                s_axi_rvalid, s_axi_rlast, s_axi_bresp, s_axi_rresp,
                                s_axi_bid, s_axi_rid}), 64'(0));
    check_eq("reset_rdata", 64'(s_axi_rdata), 64'(0));
    reset = 1'b0;
    #1 check_eq("ready_pre_edge", 64'({s_axi_awready, s_axi_arready}), 64'(0));
    @(negedge clk);
    check_eq("ready_post_edge", 64'({s_axi_awready, s_axi_arready}), 64'(2'b11));

    // Known contents everywhere: four max-length INCR bursts.
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 256; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
      do_write(32'(c * 1024), 255, 2'd1, 3'd2, -1, 1'b0);
    end

    // Single write then read.
    wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
    do_write(32'hA8, 0, 2'd1, 3'd2, -1, 1'b0);
    do_read(32'hA8, 0, 2'd1, 3'd2, 0);

    // INCR burst 1..4, read back with toggling rready.
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
    do_write(32'h100, 3, 2'd1, 3'd2, -1, 1'b0);
    do_read(32'h100, 3, 2'd1, 3'd2, 1);

    // Byte strobes.
    wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
    do_write(32'h40, 0, 2'd1, 3'd2, -1, 1'b0);
    wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'h5;
    do_write(32'h40, 0, 2'd1, 3'd2, -1, 1'b0);
    do_read(32'h40, 0, 2'd1, 3'd2, 0);
    check_eq("strobe_model", 64'(model[widx(32'h40)]), 64'(32'h11BB33DD));

    // WRAP write is suppressed; early wlast gives SLVERR.
    wbuf[0] = 32'hCAFE0001; wbuf[1] = 32'hCAFE0002; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    do_write(32'h200, 1, 2'd2, 3'd2, -1, 1'b0);
    do_read(32'h200, 1, 2'd1, 3'd2, 0);
    do_read(32'h200, 1, 2'd2, 3'd2, 0);
    do_write(32'h300, 1, 2'd1, 3'd2, 0, 1'b0);
    do_read(32'h300, 1, 2'd1, 3'd2, 0);

    // Overlap: read beat 1 loads on the same edge the write lands -> old, old, new, new.
    old_v = model[widx(32'h500)];
    new_v = ~old_v;
    s_axi_awid = '0; s_axi_awaddr = 32'h500; s_axi_awlen = 8'd0; s_axi_awsize = 3'd2;
    s_axi_awburst = 2'd0; s_axi_awvalid = 1'b1;
    s_axi_arid = 1'b1; s_axi_araddr = 32'h500; s_axi_arlen = 8'd3; s_axi_arsize = 3'd2;
    s_axi_arburst = 2'd0; s_axi_arvalid = 1'b1;
    s_axi_wvalid = 1'b1; s_axi_wdata = new_v; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1;
    s_axi_rready = 1'b1; s_axi_bready = 1'b1;
    check_eq("ovl_idle", 64'({s_axi_awready, s_axi_arready}), 64'(2'b11));
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    check_eq("ovl_beat0", 64'(s_axi_rdata), 64'(old_v));
    @(negedge clk);
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    check_eq("ovl_beat1", 64'({s_axi_bvalid, s_axi_rdata}), 64'({1'b1, old_v}));
    @(negedge clk);
    s_axi_bready = 1'b0;
    check_eq("ovl_beat2", 64'(s_axi_rdata), 64'(new_v));
    @(negedge clk);
    check_eq("ovl_beat3", 64'({s_axi_rlast, s_axi_rdata}), 64'({1'b1, new_v}));
    @(negedge clk);
    s_axi_rready = 1'b0;
    check_eq("ovl_done", 64'({s_axi_rvalid, s_axi_arready, s_axi_awready}), 64'(3'b011));
    model[widx(32'h500)] = new_v;

    // Reset in the middle of a stalled read burst.
    s_axi_araddr = 32'h100; s_axi_arlen = 8'd3; s_axi_arburst = 2'd1; s_axi_arvalid = 1'b1;
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    check_eq("rst_rd_started", 64'(s_axi_rvalid), 64'(1));
    #2 reset = 1'b1;
    #1 check_eq("rst_async", 64'({s_axi_rvalid, s_axi_rlast, s_axi_arready, s_axi_awready}),
                64'(0));
    @(negedge clk);
    reset = 1'b0;
    #1 check_eq("rst_ready_low", 64'(s_axi_arready), 64'(0));
    @(negedge clk);
    check_eq("rst_ready_up", 64'({s_axi_arready, s_axi_awready}), 64'(2'b11));
    do_read(32'h100, 3, 2'd1, 3'd2, 0);

    // Beyond the array: DECERR or alias of word 0.
    do_read(32'h1000, 0, 2'd1, 3'd2, 0);

    // Randomized write/read pairs.
    for (int it = 0; it < 40; it++) begin
      addr = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 5) == 0) addr = addr + 32'h1000 * 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) addr = addr | 32'($urandom_range(1, 3));
      len = $urandom_range(0, 7);
      r = $urandom_range(0, 9);
      burst = (r < 5) ? 2'd1 : ((r < 8) ? 2'd0 : 2'(r - 6));
      size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      bad = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len) : -1;
      for (int i = 0; i <= len; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'($urandom); end
      do_write(addr, len, burst, size, bad, 1'b1);
      do_read(addr, len, ($urandom_range(0, 3) == 0) ? 2'd1 : burst, 3'd2,
              $urandom_range(0, 2));
      if ($urandom_range(0, 2) == 0)
        do_read(32'($urandom_range(0, 4095)) & ~32'h3, $urandom_range(0, 7), 2'd1, size, 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
